// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - NUM_CH:1 registered channel mux with manual select and round-robin auto-scan
module mux_scan_sel #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 1,
    parameter int DWELL_W = 8,
    parameter int SEL_W   = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       mode,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       hold,
    input  logic [DWELL_W-1:0]         dwell,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [SEL_W-1:0]           cur_ch,
    output logic                       ch_change
);

    logic [SEL_W-1:0]   scan_ch;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SEL_W-1:0]   eff_ch;
    logic [DATA_W-1:0]  eff_data;
    logic [DATA_W-1:0]  ch_data [NUM_CH];

    // Unpack the flat input bus so the channel pick is a plain array index;
    // NUM_CH is a power of two, so every eff_ch value names a real channel.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = data_in[k*DATA_W +: DATA_W];
    end

    assign eff_ch   = mode ? scan_ch : sel;
    assign eff_data = ch_data[eff_ch];

    // Output stage: present the effective channel one cycle after selection.
    // ch_change is a single-cycle pulse, so it drops on any stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            cur_ch    <= '0;
            ch_change <= 1'b0;
        end else if (ena) begin
            data_out  <= eff_data;
            cur_ch    <= eff_ch;
            ch_change <= (eff_ch != cur_ch);
        end else begin
            ch_change <= 1'b0;
        end
    end

    // Scan engine: in manual mode it shadows sel with a cleared dwell count,
    // so a switch to auto-scan begins on the last manual channel with a full
    // dwell period. A dwell lowered below the running count is not treated as
    // expiry; the counter runs on and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch   <= '0;
            dwell_cnt <= '0;
        end else if (ena) begin
            if (!mode) begin
                scan_ch   <= sel;
                dwell_cnt <= '0;
            end else if (!hold) begin
                if (dwell_cnt == dwell) begin
                    dwell_cnt <= '0;
                    scan_ch   <= scan_ch + 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb/tb_mux_scan_sel.sv - randomized and directed self-checking bench for mux_scan_sel
module tb_mux_scan_sel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_ena = 1'b0, a_mode = 1'b0, a_hold = 1'b0;
    logic [1:0]  a_sel = '0;
    logic [7:0]  a_dwell = '0;
    logic [3:0]  a_data = '0;
    logic [0:0]  a_data_out;
    logic [1:0]  a_cur_ch;
    logic        a_ch_change;

    logic        b_ena = 1'b0, b_mode = 1'b0, b_hold = 1'b0;
    logic [2:0]  b_sel = '0;
    logic [7:0]  b_dwell = '0;
    logic [31:0] b_data = '0;
    logic [3:0]  b_data_out;
    logic [2:0]  b_cur_ch;
    logic        b_ch_change;

    int n_checks = 0;
    int n_fail   = 0;

    int m_scan [2];
    int m_cnt  [2];
    int m_out  [2];
    int m_cur  [2];
    int m_chg  [2];
    int m_n    [2] = '{4, 8};
    int m_w    [2] = '{1, 4};

    always #5 clk = ~clk;

    mux_scan_sel #(.NUM_CH(4), .DATA_W(1), .DWELL_W(8)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (a_ena),
        .mode      (a_mode),
        .sel       (a_sel),
        .hold      (a_hold),
        .dwell     (a_dwell),
        .data_in   (a_data),
        .data_out  (a_data_out),
        .cur_ch    (a_cur_ch),
        .ch_change (a_ch_change)
    );

    mux_scan_sel #(.NUM_CH(8), .DATA_W(4), .DWELL_W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (b_ena),
        .mode      (b_mode),
        .sel       (b_sel),
        .hold      (b_hold),
        .dwell     (b_dwell),
        .data_in   (b_data),
        .data_out  (b_data_out),
        .cur_ch    (b_cur_ch),
        .ch_change (b_ch_change)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_cur[i] = 0; m_chg[i] = 0;
        end
    endtask

    // One enabled edge described by the rules: pick a channel, present it,
    // then move the scan position according to the mode.
    task automatic model_edge(input int i, input bit ena, input bit mode, input int sel,
                              input bit hold, input int dwell, input longint data);
        int ch;
        if (!ena) begin
            m_chg[i] = 0;
            return;
        end
        ch = mode ? m_scan[i] : sel;
        m_out[i] = int'((data >> (ch * m_w[i])) % (64'd1 << m_w[i]));
        m_chg[i] = (ch != m_cur[i]) ? 1 : 0;
        m_cur[i] = ch;
        if (!mode) begin
            m_scan[i] = sel;
            m_cnt[i]  = 0;
        end else if (!hold) begin
            if (m_cnt[i] == dwell) begin
                m_cnt[i]  = 0;
                m_scan[i] = (m_scan[i] + 1) % m_n[i];
            end else begin
                m_cnt[i] = (m_cnt[i] + 1) % 256;
            end
        end
    endtask

    task automatic compare_model();
        check_eq("a_data_out",  int'(a_data_out),  m_out[0]);
        check_eq("a_cur_ch",    int'(a_cur_ch),    m_cur[0]);
        check_eq("a_ch_change", int'(a_ch_change), m_chg[0]);
        check_eq("b_data_out",  int'(b_data_out),  m_out[1]);
        check_eq("b_cur_ch",    int'(b_cur_ch),    m_cur[1]);
        check_eq("b_ch_change", int'(b_ch_change), m_chg[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, a_ena, a_mode, int'(a_sel), a_hold, int'(a_dwell), longint'(a_data));
        model_edge(1, b_ena, b_mode, int'(b_sel), b_hold, int'(b_dwell), longint'(b_data));
        #1;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_a_data_out"},  int'(a_data_out),  0);
        check_eq({tag, "_a_cur_ch"},    int'(a_cur_ch),    0);
        check_eq({tag, "_a_ch_change"}, int'(a_ch_change), 0);
        check_eq({tag, "_b_data_out"},  int'(b_data_out),  0);
        check_eq({tag, "_b_cur_ch"},    int'(b_cur_ch),    0);
        check_eq({tag, "_b_ch_change"}, int'(b_ch_change), 0);
    endtask

    // Asynchronous reset dropped between edges; outputs must clear at once.
    task automatic reset_mid(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_scan [13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
        int exp_gate [3]  = '{0, 0, 1};
        int hold_val;
        int guard;
        logic [3:0] pat;

        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Release and first manual transfer
        a_ena = 1'b1; a_mode = 1'b0; a_sel = 2'd0; a_data = 4'b0001;
        step();
        check_eq("first_data_out", int'(a_data_out), 1);

        // Manual stepping over a 1010 pattern
        a_data = 4'b1010;
        pat = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            step();
            check_eq("man_cur_ch",    int'(a_cur_ch),    s);
            check_eq("man_data_out",  int'(a_data_out),  int'(pat[s]));
            check_eq("man_ch_change", int'(a_ch_change), (s != 0) ? 1 : 0);
        end

        // Auto-scan with dwell=2 starting from sel=1
        a_sel = 2'd1;
        step();
        a_mode = 1'b1; a_dwell = 8'd2; a_data = 4'b0110;
        pat = 4'b0110;
        for (int i = 0; i < 13; i++) begin
            step();
            check_eq("scan_cur_ch",    int'(a_cur_ch),    exp_scan[i]);
            check_eq("scan_data_out",  int'(a_data_out),  int'(pat[exp_scan[i]]));
            check_eq("scan_ch_change", int'(a_ch_change), (i % 3 == 0 && i > 0) ? 1 : 0);
        end

        // Dwell=0 advances every cycle, then hold freezes the scan
        a_mode = 1'b0; a_sel = 2'd0;
        step();
        a_mode = 1'b1; a_dwell = 8'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("fast_cur_ch", int'(a_cur_ch), i % 4);
        end
        a_hold = 1'b1;
        step();
        hold_val = int'(a_cur_ch);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("hold_cur_ch",    int'(a_cur_ch),    hold_val);
            check_eq("hold_ch_change", int'(a_ch_change), 0);
        end
        a_hold = 1'b0;
        step();
        step();
        check_eq("unhold_cur_ch", int'(a_cur_ch), (hold_val + 1) % 4);

        // ena gating mid-dwell with dwell=3
        a_mode = 1'b0; a_sel = 2'd0; a_data = 4'b0101;
        step();
        a_mode = 1'b1; a_dwell = 8'd3;
        step();
        step();
        a_ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_data = 4'($urandom);
            step();
            check_eq("gate_cur_ch",    int'(a_cur_ch),    0);
            check_eq("gate_data_out",  int'(a_data_out),  1);
            check_eq("gate_ch_change", int'(a_ch_change), 0);
        end
        a_ena = 1'b1; a_data = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("regate_cur_ch", int'(a_cur_ch), exp_gate[i]);
        end

        // Reset mid-scan on the 8-channel, 4-bit instance
        b_ena = 1'b1; b_mode = 1'b0; b_sel = 3'd0; b_dwell = 8'd5; b_data = $urandom;
        step();
        b_mode = 1'b1;
        guard = 0;
        while (m_cur[1] != 6 && guard < 100) begin
            step();
            guard++;
        end
        check_eq("reach_ch6_b_cur_ch", int'(b_cur_ch), 6);
        reset_mid("midscan");
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("post_rst_b_cur_ch",    int'(b_cur_ch),    (i < 6) ? 0 : 1);
            check_eq("post_rst_b_ch_change", int'(b_ch_change), (i == 6) ? 1 : 0);
        end

        // Randomized traffic on both instances against the model
        for (int t = 0; t < 1500; t++) begin
            a_ena  = ($urandom_range(9) != 0);
            b_ena  = ($urandom_range(9) != 0);
            if ($urandom_range(15) == 0) a_mode = ~a_mode;
            if ($urandom_range(15) == 0) b_mode = ~b_mode;
            a_sel  = 2'($urandom);
            b_sel  = 3'($urandom);
            a_hold = ($urandom_range(4) == 0);
            b_hold = ($urandom_range(4) == 0);
            if ($urandom_range(19) == 0) a_dwell = 8'($urandom_range(3));
            if ($urandom_range(19) == 0) b_dwell = 8'($urandom_range(4));
            a_data = 4'($urandom);
            b_data = $urandom;
            step();
            if ($urandom_range(199) == 0) reset_mid("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised successor to the team's 4:1 pin mux. Selects one of NUM_CH channels, each DATA_W bits wide, and drives a registered output.
- Two modes:
  - Manual: channel chosen by the sel input.
  - Auto-scan: round-robin through all channels, staying on each for a programmable dwell time.
- Sits behind the TinyTapeout user-pin wrapper: data from ui_in/uio_in slices, result to uo_out.

Parameters:
- NUM_CH, 4: number of input channels; power of two, >= 2.
- DATA_W, 1: bits per channel.
- DWELL_W, 8: width of the dwell-count input and the internal dwell counter.
- SEL_W, $clog2(NUM_CH): channel index width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; when 0, all state holds.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  manual channel index.
- hold  in  1  auto-scan only: freeze dwell counter and scan index.
- dwell  in  DWELL_W  cycles per channel minus one (0 = advance every enabled cycle).
- data_in  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- data_out  out  DATA_W  registered selected channel data.
- cur_ch  out  SEL_W  index of the channel currently presented on data_out.
- ch_change  out  1  one-cycle pulse when cur_ch takes a new value.

Behaviour:
- Reset (rst_n=0, asynchronous): data_out=0, cur_ch=0, ch_change=0, scan_ch=0, dwell_cnt=0. Reset mid-scan aborts immediately. After release, scanning restarts from channel 0 with dwell_cnt=0.
- All state updates only on rising clk with ena=1. ena=0 holds every register. ch_change is forced to 0 on a cycle with ena=0.
- Effective channel: eff_ch = mode ? scan_ch : sel (combinational).
- Each enabled cycle, in the same edge:
  - data_out <= data_in slice[eff_ch].
  - cur_ch <= eff_ch.
  - ch_change <= (eff_ch != cur_ch).
- Latency: data_in or sel change to data_out is 1 cycle.
- Manual mode (mode=0):
  - scan_ch <= sel.
  - dwell_cnt <= 0.
  - hold is ignored.
- Auto mode (mode=1, hold=0):
  - If dwell_cnt == dwell: dwell_cnt <= 0 and scan_ch <= scan_ch+1, wrapping NUM_CH-1 -> 0.
  - Otherwise dwell_cnt <= dwell_cnt+1.
  - Each channel is therefore presented for dwell+1 enabled cycles.
- Auto mode with hold=1: scan_ch and dwell_cnt hold. data_out keeps sampling data_in[scan_ch] every cycle.
- Manual -> auto switch: scanning starts from the last sel value with a full dwell period, because scan_ch already tracks sel and dwell_cnt=0.
- Auto -> manual switch: takes effect at the next edge. sel overrides; dwell_cnt is cleared.
- dwell changed mid-period: the comparison uses the current dwell value. If dwell_cnt > new dwell, the counter increments until it wraps at 2^DWELL_W. No early advance; this is the documented behaviour.
- dwell_cnt width is DWELL_W, unsigned.
- No illegal sel values exist (NUM_CH is a power of two). No X propagation from unused bits.

Test Plan:
- Reset/default (NUM_CH=4, DATA_W=1): assert rst_n=0 asynchronously mid-cycle -> data_out=0, cur_ch=0, ch_change=0 immediately; release, ena=1, mode=0, sel=0, data_in=4'b0001 -> data_out=1 after 1 edge.
- Manual select:
  - Setup: data_in=4'b1010, step sel 0,1,2,3 one per cycle.
  - data_out: 0,1,0,1, each one cycle after its sel.
  - cur_ch: 0,1,2,3.
  - ch_change: high on each of the steps to 1, 2 and 3.
- Auto-scan dwell=2:
  - Setup: from sel=1, set mode=1, data_in=4'b0110.
  - cur_ch sequence: 1,1,1,2,2,2,3,3,3,0,0,0,1.
  - ch_change: pulses exactly at the 1->2, 2->3, 3->0 and 0->1 transitions.
- Dwell=0 and hold:
  - dwell=0, mode=1: cur_ch advances every cycle, 0,1,2,3,0.
  - Assert hold for 5 cycles: cur_ch frozen, ch_change=0.
  - Deassert hold: advance resumes the next cycle.
- ena gating: drop ena for 4 cycles during auto scan with dwell=3 -> cur_ch, data_out and dwell_cnt unchanged, ch_change=0; on re-enable, the remaining dwell count continues from where it stopped.
- Reset mid-scan: NUM_CH=8, DATA_W=4, dwell=5, reset while cur_ch=6 -> outputs 0 immediately; after release in auto mode, cur_ch=0 for 6 cycles, then 1.
